// File: rtl/pipe_adder.sv
// Segmented ripple-carry add/sub pipeline: STAGES carry segments, result STAGES cycles after transfer.
// Global stall: when the output is held (out_valid && !out_ready) every stage freezes and in_ready drops.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cry_q, cry_d;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1's registers.
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] src_cry;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];

  logic              advance;
  logic [SEG:0]      seg_sum;

  always_comb begin
    advance    = !vld_q[LAST] || out_ready;
    seg_sum    = '0;
    src_vld[0] = in_valid;
    src_cry[0] = sub ? 1'b1 : cin;
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_cry[k] = cry_q[k-1];
      src_a[k]   = opa_q[k-1];
      src_b[k]   = opb_q[k-1];
      src_sum[k] = sum_q[k-1];
    end

    vld_d = vld_q;
    cry_d = cry_q;
    for (int k = 0; k < STAGES; k++) begin
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      sum_d[k] = sum_q[k];
    end

    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        seg_sum  = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
                 + (SEG+1)'(src_cry[k]);
        vld_d[k] = src_vld[k];
        cry_d[k] = seg_sum[SEG];
        opa_d[k] = src_a[k];
        opb_d[k] = src_b[k];
        sum_d[k] = src_sum[k];
        sum_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cry_q <= '0;
      opa_q <= '{default: '0};
      opb_q <= '{default: '0};
      sum_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      cry_q <= cry_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      sum_q <= sum_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[LAST];
  assign y         = sum_q[LAST];
  assign co        = cry_q[LAST];
  // opb carries b already inverted for subtract, so this is the b' sign.
  assign ovf       = (opa_q[LAST][WIDTH-1] == opb_q[LAST][WIDTH-1]) &&
                     (sum_q[LAST][WIDTH-1] != opa_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: corner sums, stalled stream, mid-flight reset, parameter sweep.
module tb_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, y;
  logic        cin, sub, co, ovf;

  logic        sw_vld, sw_cin, sw_sub, sw_ordy;
  logic [31:0] sw_a, sw_b;
  logic [3:0]  sw_rdy, sw_ov, sw_co, sw_ovf;
  logic [3:0][31:0] sw_y;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .co(co), .ovf(ovf)
  );

  for (genvar i = 0; i < 4; i++) begin : g_sw
    localparam int W = (i == 3) ? 32 : 16;
    localparam int S = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 16 : 8;
    logic [W-1:0] yy;
    pipe_adder #(.WIDTH(W), .STAGES(S)) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_vld), .in_ready(sw_rdy[i]),
      .a(sw_a[W-1:0]), .b(sw_b[W-1:0]), .cin(sw_cin), .sub(sw_sub),
      .out_valid(sw_ov[i]), .out_ready(sw_ordy), .y(yy), .co(sw_co[i]), .ovf(sw_ovf[i])
    );
    assign sw_y[i] = 32'(yy);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a + b' + c0 computed wide, then truncated to w bits.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] v,
                                          input logic c, input logic s);
    logic [63:0] mask, bp, full;
    logic [31:0] r;
    logic        cc, ov;
    mask = (64'd1 << w) - 64'd1;
    bp   = (s ? ~{32'd0, v} : {32'd0, v}) & mask;
    full = ({32'd0, x} & mask) + bp + (s ? 64'd1 : {63'd0, c});
    r    = 32'(full & mask);
    cc   = full[w];
    ov   = (x[w-1] == bp[w-1]) && (r[w-1] != x[w-1]);
    return {ov, cc, r};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts,
                        input logic [15:0] ey, input logic eco, input logic eovf);
    int lat;
    a = ta; b = tb; cin = tc; sub = ts; out_ready = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_y"}, 64'(y), 64'(ey));
    chk({tag, "_co"}, 64'(co), 64'(eco));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eovf));
    tick();
  endtask

  logic [15:0] str_y [8] = '{16'h0F0F, 16'h2021, 16'h3131, 16'h4243,
                             16'h5353, 16'h6465, 16'h7575, 16'h8687};
  logic        str_ovf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int          sw_w [4] = '{16, 16, 16, 32};
  int          sw_s [4] = '{1, 2, 16, 8};

  initial begin
    int idx, ridx, cyc, stalls, vcnt;
    logic held, acc;
    logic [17:0] held_v;
    logic [33:0] sw_exp [4];
    logic [3:0]  seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_vld = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_ordy = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();

    run_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("8000_m1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("5_m7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Back-to-back stream with out_ready dropped for cycles 6..8.
    idx = 0; ridx = 0; cyc = 0; stalls = 0; held = 1'b0; held_v = '0;
    sub = 1'b0;
    while (ridx < 8 && cyc < 60) begin
      in_valid  = (idx < 8);
      a         = 16'(idx * 16'h1111);
      b         = 16'h0F0F;
      cin       = idx[0];
      out_ready = !(cyc >= 6 && cyc <= 8);
      @(negedge clk);
      chk($sformatf("str_in_ready_c%0d", cyc), 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && !out_ready) begin
        stalls++;
        if (held) chk($sformatf("str_stable_c%0d", cyc), 64'({ovf, co, y}), 64'(held_v));
        else begin
          held   = 1'b1;
          held_v = {ovf, co, y};
        end
      end
      if (out_valid && out_ready) begin
        chk($sformatf("str_y%0d", ridx), 64'(y), 64'(str_y[ridx]));
        chk($sformatf("str_co%0d", ridx), 64'(co), 64'd0);
        chk($sformatf("str_ovf%0d", ridx), 64'(ovf), 64'(str_ovf[ridx]));
        ridx++;
        held = 1'b0;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    chk("str_count", 64'(ridx), 64'd8);
    chk("str_stalls", 64'(stalls), 64'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Three operations in flight, then a one-cycle reset with in_valid held high.
    for (int k = 1; k <= 3; k++) begin
      a = 16'(k); b = 16'h0000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    rst = 1'b1; a = 16'h00AA;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_in_ready", 64'(in_ready), 64'd1);
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) vcnt++;
      tick();
    end
    chk("rstmid_ghosts", 64'(vcnt), 64'd0);
    run_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Parameter sweep, one operation at a time, first vectors are carry/overflow corners.
    for (int t = 0; t < 12; t++) begin
      sw_a   = (t == 0) ? 32'hFFFF_FFFF : (t == 1) ? 32'h7FFF_7FFF : $urandom;
      sw_b   = (t == 0) ? 32'h0000_0001 : (t == 1) ? 32'h8000_8000 : $urandom;
      sw_cin = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      sw_sub = (t == 1) ? 1'b1 : (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) sw_exp[i] = ref_add(sw_w[i], sw_a, sw_b, sw_cin, sw_sub);
      seen = '0;
      chk($sformatf("sw_rdy_t%0d", t), 64'(sw_rdy), 64'hF);
      sw_vld = 1'b1;
      tick();
      sw_vld = 1'b0;
      for (int lat = 1; lat <= 20; lat++) begin
        for (int i = 0; i < 4; i++) begin
          if (!seen[i] && sw_ov[i]) begin
            seen[i] = 1'b1;
            chk($sformatf("sw%0d_lat_t%0d", i, t), 64'(lat), 64'(sw_s[i]));
            chk($sformatf("sw%0d_res_t%0d", i, t), 64'({sw_ovf[i], sw_co[i], sw_y[i]}),
                64'(sw_exp[i]));
          end
        end
        tick();
      end
      chk($sformatf("sw_seen_t%0d", t), 64'(seen), 64'hF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
